mem_sram_responder: RTL

Memory-side responder for the MEM-stage data access. It takes the MEM stage's read/write request (rd_en/wr_en, 32-bit address, 32-bit store data) and serves it from an external 16-bit asynchronous SRAM as two half-word phases with programmable wait states. It returns the 32-bit load data with a `ready` flag; the pipeline freezes all stage registers while `ready` is low.

---
 rtl/mem_sram_responder_pkg.sv | 23 ++
 rtl/sram_read_buffer.sv | 45 ++++
 rtl/mem_sram_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_sram_responder_pkg.sv
// Shared types and constants for the MEM-stage SRAM responder.
// The optional read buffer is enabled by defining MEM_RSP_READ_BUF_EN.
package mem_sram_responder_pkg;

    localparam int unsigned REGISTER_LEN  = 32;
    localparam int unsigned SRAM_DATA_LEN = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } sram_state_e;

    // Pick the half-word of a register-width value that belongs to a phase.
    function automatic logic [SRAM_DATA_LEN-1:0] half_sel(
        input logic [REGISTER_LEN-1:0] word,
        input logic                    hi
    );
        return hi ? word[REGISTER_LEN-1:SRAM_DATA_LEN] : word[SRAM_DATA_LEN-1:0];
    endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry read buffer (valid, word tag, data) for the SRAM responder.
// Only compiled when MEM_RSP_READ_BUF_EN is defined.
`ifdef MEM_RSP_READ_BUF_EN
module sram_read_buffer
    import mem_sram_responder_pkg::*;
#(
    parameter int unsigned TAG_LEN = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lookup_en,
    input  logic                    inval_en,
    input  logic [TAG_LEN-1:0]      req_tag,
    input  logic                    fill_en,
    input  logic [TAG_LEN-1:0]      fill_tag,
    input  logic [REGISTER_LEN-1:0] fill_data,
    output logic                    hit,
    output logic [REGISTER_LEN-1:0] data
);

    logic                    valid_q;
    logic [TAG_LEN-1:0]      tag_q;
    logic [REGISTER_LEN-1:0] data_q;
    logic                    tag_match;

    assign tag_match = valid_q && (tag_q == req_tag);
    assign hit       = lookup_en && tag_match;
    assign data      = data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (inval_en && tag_match) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag;
            data_q  <= fill_data;
        end
    end

endmodule
`endif

// File: rtl/mem_sram_responder.sv
// MEM-stage responder serving 32-bit loads/stores from a 16-bit async SRAM in two
// half-word phases with wait states. Optional read buffer: MEM_RSP_READ_BUF_EN.
module mem_sram_responder
    import mem_sram_responder_pkg::*;
#(
    parameter int unsigned            WAIT_CYCLES   = 2,
    parameter int unsigned            SRAM_ADDR_LEN = 18,
    parameter logic [REGISTER_LEN-1:0] ADDR_BASE    = 32'd1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [REGISTER_LEN-1:0]  address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n
);

    localparam int unsigned WORD_LEN = SRAM_ADDR_LEN - 1;
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES);
    localparam bit          NO_SETUP = (WAIT_CYCLES == 0);

    sram_state_e             state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_write_q;
    logic [WORD_LEN-1:0]     word_q;
    logic [REGISTER_LEN-1:0] wdata_q;
    logic [REGISTER_LEN-1:0] read_data_q;

    logic                    req;
    logic                    start;
    logic                    phase_last;
    logic                    buf_hit;
    logic [REGISTER_LEN-1:0] byte_off;
    logic [WORD_LEN-1:0]     word_d;
    logic                    unused_off;

    assign req        = rd_en | wr_en;
    assign start      = (state_q == StIdle) && req;
    assign phase_last = (cnt_q == LAST_CNT);

    // SRAM word index; the half-word select bit comes from the phase.
    assign byte_off   = address - ADDR_BASE;
    assign word_d     = byte_off[SRAM_ADDR_LEN:2];
    assign unused_off = ^{byte_off[REGISTER_LEN-1:SRAM_ADDR_LEN+1], byte_off[1:0]};

`ifdef MEM_RSP_READ_BUF_EN
    logic [REGISTER_LEN-1:0] buf_data;

    sram_read_buffer #(
        .TAG_LEN (WORD_LEN)
    ) u_read_buffer (
        .clk       (clk),
        .rst       (rst),
        .lookup_en ((state_q == StIdle) && rd_en),
        .inval_en  ((state_q == StIdle) && wr_en),
        .req_tag   (word_d),
        .fill_en   ((state_q == StDone) && !is_write_q),
        .fill_tag  (word_q),
        .fill_data (read_data_q),
        .hit       (buf_hit),
        .data      (buf_data)
    );
`else
    assign buf_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a dropped request does not abort an access in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cnt_d   = 4'd0;
                    state_d = buf_hit ? StDone : StLo;
                end
            end
            StLo: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = StHi;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHi: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request is latched at start so a flush cannot disturb the second phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            if (start) begin
                is_write_q <= wr_en;
                word_q     <= word_d;
                wdata_q    <= write_data;
            end
            if (!is_write_q && phase_last) begin
                if (state_q == StLo) begin
                    read_data_q[SRAM_DATA_LEN-1:0] <= sram_dq_in;
                end else if (state_q == StHi) begin
                    read_data_q[REGISTER_LEN-1:SRAM_DATA_LEN] <= sram_dq_in;
                end
            end
`ifdef MEM_RSP_READ_BUF_EN
            if (start && buf_hit) begin
                read_data_q <= buf_data;
            end
`endif
        end
    end

    // Output logic
    always_comb begin
        logic in_phase;
        in_phase    = (state_q == StLo) || (state_q == StHi);
        ready       = ~req | (state_q == StDone);
        read_data   = read_data_q;
        sram_addr   = {word_q, state_q == StHi};
        sram_dq_out = half_sel(wdata_q, state_q == StHi);
        sram_dq_oe  = in_phase && is_write_q;
        // First cycle of each write phase is address setup, unless there is only one.
        sram_we_n   = ~(sram_dq_oe && (NO_SETUP || (cnt_q != 4'd0)));
    end

endmodule
